regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register-file write port between NUM_REQ requesters (ALU, load unit, move unit, ...).
//  Drives the 4-to-16 write-select decoder and gates its one-hot output.
//  Round-robin arbitration; one write slot per grant, which removes write-port contention.
//  Sits between execute/writeback producers and the decoder + 16x32 register file.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  ADDR_W   4   register address width (decoder input width)
//  DATA_W   32  write data width
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               synchronous active-low reset
//  req_valid  in   NUM_REQ         requester i holds a pending write
//  req_addr   in   NUM_REQ*ADDR_W  dest reg, slice i = [i*ADDR_W +: ADDR_W]
//  req_data   in   NUM_REQ*DATA_W  write data, slice i = [i*DATA_W +: DATA_W]
//  req_ready  out  NUM_REQ         one-hot accept; transfer when valid&ready
//  wr_stall   in   1               regfile busy; holds the pending write
//  dec_in     out  ADDR_W          select into 4-to-16 decoder
//  wr_en      out  1               gates decoder enable; regfile writes when 1
//  wr_data    out  DATA_W          data to regfile
//  grant_id   out  $clog2(NUM_REQ) index of requester owning the pending write
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, pend_valid=0, rr_ptr=0, dec_in=0, wr_data=0,
//    grant_id=0. wr_en=0 and req_ready=0 while rst_n=0. A pending write is dropped, not issued.
//  - One pending-write register (pend_valid/addr/data/id). FSM: IDLE (empty), BUSY (full).
//  - Combinational outputs: wr_en = pend_valid & ~wr_stall. dec_in/wr_data/grant_id come from pend_*.
//  - Accept condition: can_accept = ~pend_valid | wr_en, i.e. empty, or draining this cycle.
//  - Arbitration: winner = first i with req_valid[i], searching from rr_ptr upward with wrap.
//    When can_accept, req_ready = onehot(winner). Otherwise req_ready=0.
//  - On a transfer: pend_* <= winner's slices, state BUSY, rr_ptr <= (winner+1) mod NUM_REQ.
//    With no transfer, rr_ptr is held.
//  - Transitions:
//      IDLE -> BUSY on transfer.
//      BUSY & wr_en & transfer -> BUSY, back-to-back at 1 write/cycle.
//      BUSY & wr_en & no valid -> IDLE.
//      BUSY & wr_stall -> BUSY; pend_* held and req_ready=0.
//  - Latency: accept in cycle N -> wr_en in cycle N+1 if not stalled.
//  - Same address from two requesters: serialized in grant order, so the last grant wins in the regfile.
//  - wr_stall asserted the same cycle pend_valid rises: no write; entry held until stall drops.
//  - req_valid dropped without ready: legal; the requester leaves arbitration.
// CONFIGURATION
//  Macro REGFILE_R0_ZERO_EN.
//  - Defined: R0 is hardwired zero.
//    - A request to addr 0 is accepted normally and consumes its arbitration turn.
//    - It is never loaded into pend_*, so it produces no wr_en pulse.
//    - From IDLE it stays IDLE.
//  - Undefined: addr 0 is written like any other register.
// STRUCTURE
//  - Package regfile_arb_pkg:
//    - REG_ADDR_W=4, NUM_REGS=16, REG_DATA_W=32.
//    - arb_state_t enum {IDLE, BUSY}.
//  - Sub-module rr_priority_picker(NUM_REQ): req_valid + rr_ptr -> one-hot winner + index.
//    Purely combinational.
//  - Top module holds the FSM, pending register and pointer.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with req_valid=4'b1111 -> req_ready=0, wr_en=0.
//    First grant after release goes to req 0.
//  2 Round-robin: all 4 valid continuously, addr i+1 -> grants 0,1,2,3,0 on consecutive cycles.
//    wr_en high every cycle from cycle 2; dec_in=1,2,3,4,1.
//  3 Stall: pending addr 5 data 32'hDEAD_BEEF, wr_stall=1 for 3 cycles -> wr_en=0, dec_in=5 held,
//    req_ready=0. Then wr_en=1 on the first cycle wr_stall=0.
//  4 Collision: req1 addr 7 data 32'h11, req2 addr 7 data 32'h22, same cycle, rr_ptr=0 ->
//    write 11 then 22. Regfile r7=32'h22.
//  5 R0 (REGFILE_R0_ZERO_EN defined): req0 addr 0 -> ready pulses, wr_en stays 0.
//    Undefined: wr_en=1 with dec_in=0.
//  6 Reset mid-op: pend_valid=1 with wr_stall=1, then rst_n=0 one cycle ->
//    pend dropped, no wr_en after release, rr_ptr=0.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and sizes for the register-file write arbiter.
// The top module also honours the optional REGFILE_R0_ZERO_EN macro (R0 hardwired to zero).
package regfile_arb_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int NUM_REGS   = 16;
   localparam int REG_DATA_W = 32;

   // IDLE: pending-write slot empty, BUSY: slot holds one write
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Index of the requester after idx, wrapping at n
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_picker.sv
// Round-robin priority picker: first valid requester at or after rr_ptr, with wrap.
// Purely combinational; produces a one-hot grant plus its index.
module rr_priority_picker
   import regfile_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant_onehot,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   int unsigned    cand_int;
   logic [IDX_W-1:0] cand;

   // Walk the ring starting at rr_ptr; the first hit wins and later hits are ignored
   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      grant_any    = 1'b0;
      cand_int     = 0;
      cand         = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_int = int'(rr_ptr) + k;
         if (cand_int >= NUM_REQ) begin
            cand_int = cand_int - NUM_REQ;
         end
         cand = IDX_W'(cand_int);
         if (!grant_any && req_valid[cand]) begin
            grant_any          = 1'b1;
            grant_onehot[cand] = 1'b1;
            grant_idx          = cand;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between NUM_REQ producers.
// Optional macro REGFILE_R0_ZERO_EN: writes to register 0 are accepted but discarded.
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = REG_ADDR_W,
   parameter int DATA_W  = REG_DATA_W,
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      wr_stall,
   output logic [ADDR_W-1:0]         dec_in,
   output logic                      wr_en,
   output logic [DATA_W-1:0]         wr_data,
   output logic [IDX_W-1:0]          grant_id
);

   arb_state_t        state;
   logic              pend_valid;
   logic [ADDR_W-1:0] pend_addr;
   logic [DATA_W-1:0] pend_data;
   logic [IDX_W-1:0]  pend_id;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  rr_next;

   logic [NUM_REQ-1:0] win_onehot;
   logic [IDX_W-1:0]   win_idx;
   logic               win_any;
   logic               can_accept;
   logic               transfer;
   logic               load_pend;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_valid    (req_valid),
      .rr_ptr       (rr_ptr),
      .grant_onehot (win_onehot),
      .grant_idx    (win_idx),
      .grant_any    (win_any)
   );

   assign pend_valid = (state == BUSY);

   // Outputs are gated by rst_n so nothing is issued or accepted while reset is held
   assign wr_en      = rst_n & pend_valid & ~wr_stall;
   assign can_accept = rst_n & (~pend_valid | wr_en);
   assign req_ready  = can_accept ? win_onehot : '0;
   assign transfer   = can_accept & win_any;

   assign dec_in   = pend_addr;
   assign wr_data  = pend_data;
   assign grant_id = pend_id;

   assign rr_next = IDX_W'(wrap_inc(int'(win_idx), NUM_REQ));

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_onehot[i]) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // A write to R0 still wins its turn but never occupies the pending slot
`ifdef REGFILE_R0_ZERO_EN
   assign load_pend = transfer & (sel_addr != '0);
`else
   assign load_pend = transfer;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         pend_addr <= '0;
         pend_data <= '0;
         pend_id   <= '0;
      end else begin
         if (transfer) begin
            rr_ptr <= rr_next;
         end
         case (state)
            IDLE: begin
               if (load_pend) begin
                  state     <= BUSY;
                  pend_addr <= sel_addr;
                  pend_data <= sel_data;
                  pend_id   <= win_idx;
               end
            end
            BUSY: begin
               if (wr_en) begin
                  if (load_pend) begin
                     pend_addr <= sel_addr;
                     pend_data <= sel_data;
                     pend_id   <= win_idx;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a transaction-level reference model.
module tb_regfile_write_arbiter;

   localparam int NR = 4;
   localparam int AW = 4;
   localparam int DW = 32;
   localparam int IW = 2;

`ifdef REGFILE_R0_ZERO_EN
   localparam bit R0Z = 1'b1;
`else
   localparam bit R0Z = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR-1:0]    req_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic             wr_stall;
   logic [AW-1:0]    dec_in;
   logic             wr_en;
   logic [DW-1:0]    wr_data;
   logic [IW-1:0]    grant_id;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [IW-1:0] id;
   } wr_t;

   wr_t           sb[$];
   logic [DW-1:0] tb_rf[16];
   int            checks   = 0;
   int            failures = 0;

   // Reference model: the single pending-write slot and the round-robin pointer
   bit m_pend = 1'b0;
   int m_ptr  = 0;

   regfile_write_arbiter #(
      .NUM_REQ (NR),
      .ADDR_W  (AW),
      .DATA_W  (DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wr_stall  (wr_stall),
      .dec_in    (dec_in),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .grant_id  (grant_id)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle of stimulus; returns just after the falling edge so outputs are settled
   task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                                input logic [NR*DW-1:0] d, input logic stall, input logic rn);
      @(posedge clk);
      #1;
      req_valid = v;
      req_addr  = a;
      req_data  = d;
      wr_stall  = stall;
      rst_n     = rn;
      @(negedge clk);
      #1;
   endtask

   // Monitor + model: compare this cycle's outputs, then advance the model to the next edge
   always @(negedge clk) begin
      logic [NR-1:0] exp_ready;
      bit            exp_wr_en;
      int            win;
      int            c;
      wr_t           e;
      wr_t           got;
      exp_wr_en = rst_n && m_pend && !wr_stall;
      exp_ready = '0;
      win       = -1;
      if (rst_n && (!m_pend || exp_wr_en)) begin
         for (int k = 0; k < NR; k++) begin
            c = (m_ptr + k) % NR;
            if (win < 0 && req_valid[c]) win = c;
         end
      end
      if (win >= 0) exp_ready[win] = 1'b1;
      checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
      checkOutput("wr_en", 64'(wr_en), 64'(exp_wr_en));
      if (wr_en === 1'b1) begin
         checkOutput("sb_has_entry", 64'(sb.size() > 0), 64'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("dec_in", 64'(dec_in), 64'(e.addr));
            checkOutput("wr_data", 64'(wr_data), 64'(e.data));
            checkOutput("grant_id", 64'(grant_id), 64'(e.id));
         end
         tb_rf[dec_in] = wr_data;
      end
      if (!rst_n) begin
         m_pend = 1'b0;
         m_ptr  = 0;
         sb.delete();
      end else begin
         if (exp_wr_en) m_pend = 1'b0;
         if (win >= 0) begin
            m_ptr    = (win + 1) % NR;
            got.addr = req_addr[win*AW +: AW];
            got.data = req_data[win*DW +: DW];
            got.id   = IW'(win);
            if (!(R0Z && got.addr == '0)) begin
               m_pend = 1'b1;
               sb.push_back(got);
            end
         end
      end
   end

   initial begin
      logic [NR-1:0]    v;
      logic [NR*AW-1:0] a;
      logic [NR*DW-1:0] d;
      logic [NR-1:0]    seen;
      logic             st;

      rst_n     = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      wr_stall  = 1'b0;
      for (int r = 0; r < 16; r++) tb_rf[r] = '0;

      // Reset held with everyone requesting, then continuous round-robin
      a = {4'd4, 4'd3, 4'd2, 4'd1};
      d = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
      for (int k = 0; k < 2; k++) begin
         applyStimulus(4'b1111, a, d, 1'b0, 1'b0);
         checkOutput("rst_ready", 64'(req_ready), 64'd0);
         checkOutput("rst_wr_en", 64'(wr_en), 64'd0);
      end
      checkOutput("rst_dec_in", 64'(dec_in), 64'd0);
      checkOutput("rst_wr_data", 64'(wr_data), 64'd0);
      checkOutput("rst_grant_id", 64'(grant_id), 64'd0);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(4'b1111, a, d, 1'b0, 1'b1);
         checkOutput("rr_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
         if (k >= 1) begin
            checkOutput("rr_wr_en", 64'(wr_en), 64'd1);
            checkOutput("rr_dec_in", 64'(dec_in), 64'(((k - 1) % 4) + 1));
         end
      end

      // Stall holds the pending write and blocks new grants
      applyStimulus(4'b0000, a, d, 1'b0, 1'b1);
      applyStimulus(4'b0000, a, d, 1'b0, 1'b1);
      applyStimulus(4'b0001, {4'd0, 4'd0, 4'd0, 4'd5}, {96'h0, 32'hDEAD_BEEF}, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(4'b1110, a, d, 1'b1, 1'b1);
         checkOutput("stall_wr_en", 64'(wr_en), 64'd0);
         checkOutput("stall_dec_in", 64'(dec_in), 64'd5);
         checkOutput("stall_ready", 64'(req_ready), 64'd0);
      end
      applyStimulus(4'b0000, a, d, 1'b0, 1'b1);
      checkOutput("unstall_wr_en", 64'(wr_en), 64'd1);
      checkOutput("unstall_data", 64'(wr_data), 64'hDEAD_BEEF);

      // Two requesters to r7 in the same cycle: the later grant lands last
      applyStimulus(4'b0000, a, d, 1'b0, 1'b0);
      applyStimulus(4'b0110, {4'd0, 4'd7, 4'd7, 4'd0}, {32'h0, 32'h22, 32'h11, 32'h0}, 1'b0, 1'b1);
      applyStimulus(4'b0100, {4'd0, 4'd7, 4'd7, 4'd0}, {32'h0, 32'h22, 32'h11, 32'h0}, 1'b0, 1'b1);
      checkOutput("coll_first", 64'(wr_data), 64'h11);
      applyStimulus(4'b0000, a, d, 1'b0, 1'b1);
      checkOutput("coll_second", 64'(wr_data), 64'h22);
      applyStimulus(4'b0000, a, d, 1'b0, 1'b1);
      checkOutput("coll_r7", 64'(tb_rf[7]), 64'h22);

      // Write to register 0
      applyStimulus(4'b0001, {16'h0}, {96'h0, 32'h5555_AAAA}, 1'b0, 1'b1);
      checkOutput("r0_ready", 64'(req_ready), 64'd1);
      applyStimulus(4'b0000, a, d, 1'b0, 1'b1);
      checkOutput("r0_wr_en", 64'(wr_en), 64'(!R0Z));

      // Reset while a stalled write is pending drops it and rewinds the pointer
      applyStimulus(4'b0000, a, d, 1'b0, 1'b1);
      applyStimulus(4'b0001, {4'd0, 4'd0, 4'd0, 4'd9}, {96'h0, 32'hAA}, 1'b1, 1'b1);
      applyStimulus(4'b0000, a, d, 1'b1, 1'b1);
      checkOutput("mid_stall_wr_en", 64'(wr_en), 64'd0);
      applyStimulus(4'b0000, a, d, 1'b1, 1'b0);
      applyStimulus(4'b0000, a, d, 1'b0, 1'b1);
      checkOutput("mid_drop_wr_en", 64'(wr_en), 64'd0);
      applyStimulus(4'b1111, a, d, 1'b0, 1'b1);
      checkOutput("mid_ptr_ready", 64'(req_ready), 64'd1);
      applyStimulus(4'b0000, a, d, 1'b0, 1'b1);
      applyStimulus(4'b0000, a, d, 1'b0, 1'b1);

      // Randomized traffic: requesters hold until accepted, occasionally give up
      v    = '0;
      seen = '0;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (seen[i] || !v[i]) begin
               v[i]             = ($urandom_range(0, 99) < 60);
               a[i*AW +: AW]    = AW'($urandom_range(0, 15));
               d[i*DW +: DW]    = $urandom;
            end else if ($urandom_range(0, 99) < 10) begin
               v[i] = 1'b0;
            end
         end
         st = ($urandom_range(0, 99) < 25);
         applyStimulus(v, a, d, st, 1'b1);
         seen = req_ready;
      end

      for (int k = 0; k < 4; k++) applyStimulus(4'b0000, a, d, 1'b0, 1'b1);
      checkOutput("sb_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
